// File: rtl/trap_controller.sv
// trap_controller: sequencer and arbiter for the machine-mode CSR file port.
//
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets when
// mtvec[1:0] == 2'b01). Without it every trap uses the direct target.
//
// Ports:
//   clock, reset            system clock (rising), async active-low reset
//   cpu_csr_*               pipeline CSR access, passed through while idle
//   exc_*                   synchronous exception request, cause, pc, tval
//   mret_valid              mret at execute
//   int_pc                  mepc value for an interrupt
//   irq_msip/mtip/meip      level-sensitive interrupt lines
//   csr_addr/ren/wen/wd/rd  CSR file access port (csr_rd is combinational)
//   stall                   freeze pipeline
//   redirect_valid/pc       one-cycle fetch redirect
//
// state   | meaning
// IDLE    | pass-through, accept exception/interrupt/mret
// T_EPC   | write mepc
// T_CAUSE | write mcause
// T_TVAL  | write mtval
// T_SRD   | read mstatus
// T_SWR   | write mstatus (MPIE<=MIE, MIE<=0, MPP<=3)
// T_VEC   | read mtvec, compute target
// M_SRD   | read mstatus
// M_SWR   | write mstatus (MIE<=MPIE, MPIE<=1, MPP<=3)
// M_EPC   | read mepc, compute target
// REDIR   | redirect pulse, back to IDLE
module trap_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] cpu_csr_addr,
  input  logic        cpu_csr_ren,
  input  logic        cpu_csr_wen,
  input  logic [31:0] cpu_csr_wd,
  output logic [31:0] cpu_csr_rd,
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic [31:0] int_pc,
  input  logic        irq_msip,
  input  logic        irq_mtip,
  input  logic        irq_meip,
  output logic [11:0] csr_addr,
  output logic        csr_ren,
  output logic        csr_wen,
  output logic [31:0] csr_wd,
  input  logic [31:0] csr_rd,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_SRD, T_SWR, T_VEC, M_SRD, M_SWR, M_EPC, REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] mstat_q, mstat_d;
  logic [31:0] target_q, target_d;
  logic        shadow_mie_en_q, shadow_mie_en_d;
  logic        shadow_meie_q, shadow_meie_d;
  logic        shadow_msie_q, shadow_msie_d;
  logic        shadow_mtie_q, shadow_mtie_d;

  logic        irq_pend;
  logic [3:0]  irq_code;
  logic        accept;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;
  logic [31:0] vec_base;
  logic [31:0] vec_target;

  // Fixed priority MEI > MSI > MTI.
  always_comb begin
    irq_code = 4'd7;
    if (irq_meip && shadow_meie_q)      irq_code = 4'd11;
    else if (irq_msip && shadow_msie_q) irq_code = 4'd3;
  end

  assign irq_pend = shadow_mie_en_q &&
                    ((irq_meip && shadow_meie_q) || (irq_msip && shadow_msie_q) ||
                     (irq_mtip && shadow_mtie_q));
  assign accept = reset && (state_q == IDLE) && (exc_valid || irq_pend || mret_valid);

  always_comb begin
    trap_mstatus        = mstat_q;
    trap_mstatus[7]     = mstat_q[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = mstat_q;
    mret_mstatus[3]     = mstat_q[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  assign vec_base = {csr_rd[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  // Interrupt codes are below 16, so cause bits 30:28 are zero here.
  assign vec_target = (csr_rd[1:0] == 2'b01 && cause_q[31]) ?
                      vec_base + {cause_q[29:0], 2'b00} : vec_base;
`else
  assign vec_target = vec_base;
`endif

  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    pc_d            = pc_q;
    tval_d          = tval_q;
    mstat_d         = mstat_q;
    target_d        = target_q;
    shadow_mie_en_d = shadow_mie_en_q;
    shadow_meie_d   = shadow_meie_q;
    shadow_msie_d   = shadow_msie_q;
    shadow_mtie_d   = shadow_mtie_q;
    csr_addr        = 12'h000;
    csr_ren         = 1'b0;
    csr_wen         = 1'b0;
    csr_wd          = 32'h0;
    cpu_csr_rd      = 32'h0;
    stall           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;

    case (state_q)
      IDLE: begin
        stall      = 1'b0;
        csr_addr   = cpu_csr_addr;
        csr_ren    = cpu_csr_ren;
        csr_wen    = cpu_csr_wen;
        csr_wd     = cpu_csr_wd;
        cpu_csr_rd = csr_rd;
        if (accept) begin
          // The pipeline access in the accept cycle is dropped entirely.
          stall      = 1'b1;
          csr_wen    = 1'b0;
          cpu_csr_rd = 32'h0;
          if (exc_valid) begin
            cause_d = {1'b0, exc_cause};
            pc_d    = exc_pc;
            tval_d  = exc_tval;
            state_d = T_EPC;
          end else if (irq_pend) begin
            cause_d = {1'b1, 27'b0, irq_code};
            pc_d    = int_pc;
            tval_d  = 32'h0;
            state_d = T_EPC;
          end else begin
            state_d = M_SRD;
          end
        end
      end
      T_EPC:   begin csr_addr = 12'h341; csr_wen = 1'b1; csr_wd = pc_q;    state_d = T_CAUSE; end
      T_CAUSE: begin csr_addr = 12'h342; csr_wen = 1'b1; csr_wd = cause_q; state_d = T_TVAL;  end
      T_TVAL:  begin csr_addr = 12'h343; csr_wen = 1'b1; csr_wd = tval_q;  state_d = T_SRD;   end
      T_SRD:   begin csr_addr = 12'h300; csr_ren = 1'b1; mstat_d = csr_rd; state_d = T_SWR;   end
      T_SWR:   begin csr_addr = 12'h300; csr_wen = 1'b1; csr_wd = trap_mstatus; state_d = T_VEC; end
      T_VEC:   begin csr_addr = 12'h305; csr_ren = 1'b1; target_d = vec_target; state_d = REDIR; end
      M_SRD:   begin csr_addr = 12'h300; csr_ren = 1'b1; mstat_d = csr_rd; state_d = M_SWR;   end
      M_SWR:   begin csr_addr = 12'h300; csr_wen = 1'b1; csr_wd = mret_mstatus; state_d = M_EPC; end
      M_EPC: begin
        csr_addr = 12'h341;
        csr_ren  = 1'b1;
        target_d = {csr_rd[31:2], 2'b00};
        state_d  = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!reset) begin
      csr_ren        = 1'b0;
      csr_wen        = 1'b0;
      cpu_csr_rd     = 32'h0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
    end

    // Shadows track whatever write actually reaches the CSR file.
    if (csr_wen) begin
      if (csr_addr == 12'h300) shadow_mie_en_d = csr_wd[3];
      if (csr_addr == 12'h304) begin
        shadow_meie_d = csr_wd[11];
        shadow_msie_d = csr_wd[3];
        shadow_mtie_d = csr_wd[7];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cause_q         <= 32'h0;
      pc_q            <= 32'h0;
      tval_q          <= 32'h0;
      mstat_q         <= 32'h0;
      target_q        <= 32'h0;
      shadow_mie_en_q <= 1'b0;
      shadow_meie_q   <= 1'b0;
      shadow_msie_q   <= 1'b0;
      shadow_mtie_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cause_q         <= cause_d;
      pc_q            <= pc_d;
      tval_q          <= tval_d;
      mstat_q         <= mstat_d;
      target_q        <= target_d;
      shadow_mie_en_q <= shadow_mie_en_d;
      shadow_meie_q   <= shadow_meie_d;
      shadow_msie_q   <= shadow_msie_d;
      shadow_mtie_q   <= shadow_mtie_d;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with a small CSR file model attached
// to the controller's CSR port. The CSR file model has no reset, so its
// contents survive a controller reset.
module tb_trap_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] cpu_csr_addr;
  logic        cpu_csr_ren;
  logic        cpu_csr_wen;
  logic [31:0] cpu_csr_wd;
  logic [31:0] cpu_csr_rd;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic [31:0] int_pc;
  logic        irq_msip, irq_mtip, irq_meip;
  logic [11:0] csr_addr;
  logic        csr_ren, csr_wen;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mstatus_m = 0, mie_m = 0, mtvec_m = 0, mscratch_m = 0;
  logic [31:0] mepc_m = 0, mcause_m = 0, mtval_m = 0;

  trap_controller dut (
    .clock(clock), .reset(reset),
    .cpu_csr_addr(cpu_csr_addr), .cpu_csr_ren(cpu_csr_ren), .cpu_csr_wen(cpu_csr_wen),
    .cpu_csr_wd(cpu_csr_wd), .cpu_csr_rd(cpu_csr_rd),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .int_pc(int_pc),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .csr_addr(csr_addr), .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_wd(csr_wd),
    .csr_rd(csr_rd),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (csr_wen === 1'b1) begin
      case (csr_addr)
        12'h300: mstatus_m  <= csr_wd;
        12'h304: mie_m      <= csr_wd;
        12'h305: mtvec_m    <= csr_wd;
        12'h340: mscratch_m <= csr_wd;
        12'h341: mepc_m     <= csr_wd;
        12'h342: mcause_m   <= csr_wd;
        12'h343: mtval_m    <= csr_wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rd = 32'h0;
    case (csr_addr)
      12'h300: csr_rd = mstatus_m;
      12'h304: csr_rd = mie_m;
      12'h305: csr_rd = mtvec_m;
      12'h340: csr_rd = mscratch_m;
      12'h341: csr_rd = mepc_m;
      12'h342: csr_rd = mcause_m;
      12'h343: csr_rd = mtval_m;
      default: csr_rd = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    exc_valid   = 1'b0;
    mret_valid  = 1'b0;
    cpu_csr_wen = 1'b0;
    cpu_csr_ren = 1'b0;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    cpu_csr_addr = a;
    cpu_csr_wd   = d;
    cpu_csr_wen  = 1'b1;
    tick();
    cpu_csr_wen  = 1'b0;
  endtask

  // Runs from the accept cycle to the first IDLE cycle after REDIR.
  task automatic run_seq(input int last, input logic [31:0] exp_pc, input string tag);
    for (int c = 1; c <= last; c++) begin
      tick();
      clear_req();
      #1;
      chk({tag, " stall"}, stall, 1'b1);
      chk({tag, " redirect_valid"}, redirect_valid, (c == last));
    end
    chk({tag, " redirect_pc"}, redirect_pc, exp_pc);
    tick();
    #1;
    chk({tag, " stall after"}, stall, 1'b0);
    chk({tag, " redirect_valid after"}, redirect_valid, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    cpu_csr_addr = 12'h340;
    cpu_csr_ren  = 1'b1;
    cpu_csr_wen  = 1'b1;
    cpu_csr_wd   = 32'hFFFF;
    exc_valid    = 1'b1;
    exc_cause    = 31'd2;
    exc_pc       = 32'h0;
    exc_tval     = 32'h0;
    mret_valid   = 1'b0;
    int_pc       = 32'h0;
    irq_msip     = 1'b0;
    irq_mtip     = 1'b0;
    irq_meip     = 1'b0;

    // Reset forces outputs low even with requests present.
    #3;
    chk("rst stall", stall, 1'b0);
    chk("rst redirect_valid", redirect_valid, 1'b0);
    chk("rst redirect_pc", redirect_pc, 32'h0);
    chk("rst csr_wen", csr_wen, 1'b0);
    chk("rst csr_ren", csr_ren, 1'b0);
    chk("rst cpu_csr_rd", cpu_csr_rd, 32'h0);
    tick();
    clear_req();
    tick();
    reset = 1'b1;
    #1;
    chk("post-rst stall", stall, 1'b0);
    chk("rst write dropped", mscratch_m, 32'h0);

    // Pass-through
    cpu_write(12'h305, 32'h100);
    cpu_csr_addr = 12'h305;
    cpu_csr_ren  = 1'b1;
    #1;
    chk("pass cpu_csr_rd", cpu_csr_rd, 32'h100);
    chk("pass csr_ren", csr_ren, 1'b1);
    chk("pass csr_addr", csr_addr, 12'h305);
    tick();
    cpu_csr_ren = 1'b0;

    // Exception
    exc_valid = 1'b1; exc_cause = 31'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
    #1;
    chk("exc accept stall", stall, 1'b1);
    run_seq(7, 32'h100, "exc");
    chk("exc mepc", mepc_m, 32'h80);
    chk("exc mcause", mcause_m, 32'h2);
    chk("exc mtval", mtval_m, 32'hDEAD);
    chk("exc mstatus", mstatus_m, 32'h1800);

    // Interrupts disabled until mstatus.MIE is set
    cpu_write(12'h304, 32'h8);
    irq_msip = 1'b1;
    int_pc   = 32'h44;
    #1;
    chk("msi masked 0", stall, 1'b0);
    tick();
    chk("msi masked 1", stall, 1'b0);
    cpu_csr_addr = 12'h300; cpu_csr_wd = 32'h8; cpu_csr_wen = 1'b1;
    #1;
    chk("msi enabling write stall", stall, 1'b0);
    tick();
    cpu_csr_wen = 1'b0;
    #1;
    chk("msi accept stall", stall, 1'b1);
    run_seq(7, 32'h100, "msi");
    irq_msip = 1'b0;
    chk("msi mcause", mcause_m, 32'h80000003);
    chk("msi mepc", mepc_m, 32'h44);
    chk("msi mtval", mtval_m, 32'h0);
    chk("msi mstatus", mstatus_m, 32'h1880);

    // mret
    mret_valid = 1'b1;
    #1;
    chk("mret accept stall", stall, 1'b1);
    run_seq(4, 32'h44, "mret");
    chk("mret mstatus", mstatus_m, 32'h1888);

    // Timer interrupt with mtvec mode 1
    cpu_write(12'h304, 32'h80);
    cpu_write(12'h305, 32'h201);
    cpu_write(12'h300, 32'h8);
    irq_mtip = 1'b1;
    int_pc   = 32'h40;
    #1;
    chk("mti accept stall", stall, 1'b1);
`ifdef TRAP_VECTORED_EN
    run_seq(7, 32'h21C, "mti");
`else
    run_seq(7, 32'h200, "mti");
`endif
    irq_mtip = 1'b0;
    chk("mti mcause", mcause_m, 32'h80000007);
    chk("mti mtval", mtval_m, 32'h0);
    chk("mti mepc", mepc_m, 32'h40);

    // Exception, enabled MEI and pipeline write in the same cycle
    cpu_write(12'h340, 32'h1234);
    cpu_write(12'h304, 32'h800);
    cpu_write(12'h300, 32'h8);
    exc_valid = 1'b1; exc_cause = 31'd5; exc_pc = 32'h90; exc_tval = 32'h7;
    irq_meip  = 1'b1;
    cpu_csr_addr = 12'h340; cpu_csr_wd = 32'hBAD; cpu_csr_wen = 1'b1; cpu_csr_ren = 1'b1;
    #1;
    chk("sim accept stall", stall, 1'b1);
    chk("sim csr_wen dropped", csr_wen, 1'b0);
    chk("sim cpu_csr_rd", cpu_csr_rd, 32'h0);
    run_seq(7, 32'h200, "sim exc");
    chk("sim mcause", mcause_m, 32'h5);
    chk("sim mepc", mepc_m, 32'h90);
    chk("sim mscratch", mscratch_m, 32'h1234);
    cpu_csr_addr = 12'h300; cpu_csr_wd = 32'h8; cpu_csr_wen = 1'b1;
    tick();
    cpu_csr_wen = 1'b0;
    #1;
    chk("mei accept stall", stall, 1'b1);
`ifdef TRAP_VECTORED_EN
    run_seq(7, 32'h22C, "mei");
`else
    run_seq(7, 32'h200, "mei");
`endif
    irq_meip = 1'b0;
    chk("mei mcause", mcause_m, 32'h8000000B);

    // Reset in T_SRD
    exc_valid = 1'b1; exc_cause = 31'd1; exc_pc = 32'hA0; exc_tval = 32'h0;
    #1;
    chk("rmid accept stall", stall, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      clear_req();
    end
    #1;
    chk("rmid T_SRD ren", csr_ren, 1'b1);
    chk("rmid T_SRD addr", csr_addr, 12'h300);
    reset = 1'b0;
    #1;
    chk("rmid stall", stall, 1'b0);
    chk("rmid redirect_valid", redirect_valid, 1'b0);
    chk("rmid csr_ren", csr_ren, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("rmid idle stall", stall, 1'b0);
    tick();
    chk("rmid mepc kept", mepc_m, 32'hA0);
    cpu_csr_addr = 12'h341;
    cpu_csr_ren  = 1'b1;
    #1;
    chk("rmid idle passthrough", cpu_csr_rd, 32'hA0);
    tick();
    cpu_csr_ren = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer and port arbiter for the machine-mode CSR file. Owns the CSR file's single access port: passes pipeline CSR instructions through when idle, and on an exception, interrupt or `mret` takes the port for a fixed multi-cycle sequence. The sequence updates `mepc`, `mcause`, `mtval` and `mstatus`, reads `mtvec` or `mepc`, stalls the pipeline and issues a PC redirect. It sits between the execute stage and the CSR file.

## Interface
- No parameters.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_csr_addr` in 12: pipeline CSR address.
- `cpu_csr_ren` in 1: pipeline CSR read enable.
- `cpu_csr_wen` in 1: pipeline CSR write enable.
- `cpu_csr_wd` in 32: pipeline CSR write data.
- `cpu_csr_rd` out 32: CSR read data returned to the pipeline.
- `exc_valid` in 1: synchronous exception request.
- `exc_cause` in 31: exception code; `mcause[31]` is 0.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_tval` in 32: trap value.
- `mret_valid` in 1: `mret` at execute.
- `int_pc` in 32: PC of the oldest uncommitted instruction, used as `mepc` for an interrupt.
- `irq_msip`, `irq_mtip`, `irq_meip` in 1 each: software, timer and external interrupt lines, level-sensitive.
- `csr_addr` out 12, `csr_ren` out 1, `csr_wen` out 1, `csr_wd` out 32: to the CSR file.
- `csr_rd` in 32: from the CSR file; combinational, valid only when `ren=1` and `wen=0`.
- `stall` out 1: freeze the pipeline.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 32: new fetch PC.

## Operation
- **States:** IDLE, T_EPC, T_CAUSE, T_TVAL, T_SRD, T_SWR, T_VEC, M_SRD, M_SWR, M_EPC, REDIR.
- **IDLE pass-through:** `csr_*` = `cpu_csr_*` combinationally, and `cpu_csr_rd` = `csr_rd`.
- **Interrupt pending:** `shadow_mie_en` && any of (`irq_meip`&`shadow_meie`, `irq_msip`&`shadow_msie`, `irq_mtip`&`shadow_mtie`).
  - Priority MEI (code 11) > MSI (3) > MTI (7).
- **Acceptance:** only in IDLE. Priority exc_valid > interrupt > mret_valid.
  - In the accept cycle the pipeline CSR access is dropped: `csr_wen=0`, `cpu_csr_rd=0`.
  - Cause, PC and tval are latched.
  - Interrupt: cause = `{1'b1, 27'b0, code}`, PC = `int_pc`, tval = 0.
- **Trap path:**
  - T_EPC: write 0x341 ← PC.
  - T_CAUSE: write 0x342 ← cause.
  - T_TVAL: write 0x343 ← tval.
  - T_SRD: read 0x300 and latch it.
  - T_SWR: write 0x300 ← latched value with MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11.
  - T_VEC: read 0x305 and compute the target.
  - REDIR.
- **Direct target:** `{mtvec[31:2], 2'b00}`.
- **mret path:**
  - M_SRD: read 0x300.
  - M_SWR: write 0x300 with MIE = MPIE, MPIE = 1, MPP = 2'b11.
  - M_EPC: read 0x341; target = `{mepc[31:2], 2'b00}`.
  - REDIR.
- **REDIR:** `redirect_valid=1`, `redirect_pc` = target; next state IDLE.
- **Outside IDLE:**
  - Controller owns the port.
  - `cpu_csr_rd=0`; pipeline writes are ignored.
  - `exc_valid`, `mret_valid` and interrupts are ignored; nothing is queued.
- **Shadow bits (`shadow_mie_en`, `shadow_meie`, `shadow_msie`, `shadow_mtie`):**
  - Updated on every write that reaches the CSR file.
  - Address 0x300 updates `shadow_mie_en` = wd[3].
  - Address 0x304 updates `shadow_meie`/`shadow_msie`/`shadow_mtie` = wd[11]/wd[3]/wd[7].
  - Source may be pipeline pass-through or the controller's own T_SWR/M_SWR.
- **Idle port:** the controller drives `csr_ren=0` and `csr_wen=0` except in the states listed above.

## Timing
- **Reset (async):** state IDLE; shadows 0, matching CSR reset values. Outputs forced while `reset=0`:
  - `stall=0`, `redirect_valid=0`, `redirect_pc=0`.
  - `csr_wen=0`, `csr_ren=0`, `cpu_csr_rd=0`.
- **Requests during reset:** ignored while `reset=0`.
- **Reset mid-sequence:** aborts to IDLE. Partial CSR writes are not undone.
- **Trap timing:** accept cycle 0; T_EPC through T_VEC are cycles 1–6; REDIR is cycle 7; IDLE from cycle 8.
- **mret timing:** accept cycle 0; states at cycles 1–3; REDIR at cycle 4.
- **`stall`:**
  - Combinational 1 in the accept cycle.
  - 1 in every non-IDLE state, including REDIR.
  - Otherwise 0.
- **Request signals:** `exc_valid` and `mret_valid` are sampled only in IDLE. A new event is acceptable in the first IDLE cycle after REDIR.
- **Shadow update:** on the same clock edge as the CSR write. A write enabling interrupts can cause acceptance on the next cycle.

## Configuration
- **`TRAP_VECTORED_EN` defined:** when `mtvec[1:0]==2'b01` and the trap is an interrupt, target = `{mtvec[31:2], 2'b00}` + (code << 2).
- **`TRAP_VECTORED_EN` not defined:**
  - All traps use the direct target.
  - Mode bits are ignored. Modes 2 and 3 are treated as direct in both builds.

## Test plan
- **Exception:** `mtvec` = 0x100; `exc_valid` with cause 2, pc 0x80, tval 0xDEAD. Required:
  - `mepc`=0x80, `mcause`=2, `mtval`=0xDEAD.
  - `mstatus.MIE`=0, `MPP`=3.
  - `redirect_valid` at cycle 7 with `redirect_pc`=0x100.
  - `stall` high for cycles 0–7.
- **Timer interrupt, vectored:** `mstatus`=0x8, `mie`=0x80, `mtvec`=0x201; `irq_mtip`=1, `int_pc`=0x40. Required:
  - `mcause`=0x80000007, `mtval`=0.
  - `redirect_pc`=0x21C with `TRAP_VECTORED_EN`; 0x200 without it.
- **mret after a trap:** Required:
  - `mstatus.MIE` restored to 1, `MPIE`=1.
  - `redirect_pc` = `mepc` at cycle 4.
- **Simultaneous events:** `exc_valid`, `irq_meip` (enabled) and a pipeline write to 0x340 in the same cycle. Required:
  - The exception is taken and `mscratch` is unchanged.
  - After the sequence, with MIE re-enabled by software, the interrupt is taken with cause 0x8000000B.
- **Interrupts disabled:** `irq_msip`=1 with `mie`=0x8 and `mstatus.MIE`=0. Required:
  - No trap is taken.
  - A pipeline write of 0x8 to 0x300 causes acceptance on the next cycle.
- **Reset mid-sequence:** assert `reset` in T_SRD. Required:
  - `stall`=0 and `redirect_valid`=0 immediately.
  - IDLE after release.
  - `mepc` retains the written value until the CSR file itself resets.
